// File: rtl/axilite_rd_pipe_pkg.sv
// Shared constants and types for the AXI-Lite read pipeline.
// Holds the RRESP encodings and the issue FSM state type.
package axilite_rd_pipe_pkg;

  localparam logic [1:0] RRESP_OKAY   = 2'b00;
  localparam logic [1:0] RRESP_SLVERR = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } issue_state_e;

endpackage

// File: rtl/axilite_sync_fifo.sv
// Synchronous FIFO whose output is read straight from the storage flops.
// Storage is cleared on reset so an empty FIFO presents zero data.
module axilite_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign dout    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  // a push into a full FIFO is accepted when the head leaves in the same cycle
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/axilite_rd_pipe.sv
// AXI-Lite read slave that turns AR beats into a strobed register read port.
// Reads are issued one at a time, in order, with an optional ack timeout.
module axilite_rd_pipe
  import axilite_rd_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 40,
  parameter int DEPTH      = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,
  output logic [ADDR_WIDTH-1:0] reg_rd_addr,
  output logic                  reg_rd_en,
  input  logic [DATA_WIDTH-1:0] reg_rd_data,
  input  logic                  reg_rd_wait,
  input  logic                  reg_rd_ack,
  output logic [15:0]           timeout_errs
);

  localparam int OW = $clog2(DEPTH + 1);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int RW = DATA_WIDTH + 2;
  localparam logic [OW-1:0] DEPTH_C  = OW'(DEPTH);
  localparam logic [TW-1:0] TMO_LOAD = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  issue_state_e          state, state_n;
  logic [OW-1:0]         outstanding, outstanding_n;
  logic                  arready_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic [TW-1:0]         tmo_cnt;
  logic [15:0]           tmo_errs_q;

  logic                  ar_fire, r_fire;
  logic                  addr_push, addr_pop, addr_empty, addr_full_unused;
  logic [ADDR_WIDTH-1:0] addr_dout;
  logic                  bypass, start, busy, tmo_fire;
  logic                  resp_push, resp_empty, resp_full;
  logic [RW-1:0]         resp_din, resp_dout;
  logic                  arprot_unused;

  assign arprot_unused = ^s_axil_arprot;

  assign ar_fire = s_axil_arvalid && arready_q;
  assign r_fire  = s_axil_rvalid && s_axil_rready;
  assign busy    = (state == ST_BUSY);

  // an AR arriving into an idle pipe skips the address FIFO to keep one-cycle issue
  assign bypass    = (state == ST_IDLE) && addr_empty && ar_fire && !resp_full;
  assign addr_push = ar_fire && !bypass;
  assign addr_pop  = (state == ST_IDLE) && !addr_empty && !resp_full;
  assign start     = addr_pop || bypass;

  assign tmo_fire  = (TIMEOUT != 0) && busy && !reg_rd_ack && !reg_rd_wait && (tmo_cnt == '0);
  assign resp_push = busy && (reg_rd_ack || tmo_fire);
  assign resp_din  = reg_rd_ack ? {reg_rd_data, RRESP_OKAY}
                                : {{DATA_WIDTH{1'b0}}, RRESP_SLVERR};

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (start) state_n = ST_BUSY;
      ST_BUSY: if (reg_rd_ack || tmo_fire) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    outstanding_n = outstanding;
    if (ar_fire && !r_fire)      outstanding_n = outstanding + 1'b1;
    else if (r_fire && !ar_fire) outstanding_n = outstanding - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      outstanding <= '0;
      arready_q   <= 1'b0;
      rd_addr_q   <= '0;
      tmo_cnt     <= '0;
      tmo_errs_q  <= '0;
    end else begin
      state       <= state_n;
      outstanding <= outstanding_n;
      arready_q   <= (outstanding_n < DEPTH_C);
      if (start) begin
        rd_addr_q <= addr_pop ? addr_dout : s_axil_araddr;
        tmo_cnt   <= TMO_LOAD;
      end else if (busy && !reg_rd_wait && (tmo_cnt != '0)) begin
        tmo_cnt <= tmo_cnt - 1'b1;
      end
      if (tmo_fire && !reg_rd_ack && (tmo_errs_q != 16'hFFFF))
        tmo_errs_q <= tmo_errs_q + 1'b1;
    end
  end

  axilite_sync_fifo #(.WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)) u_addr_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (addr_push),
    .din   (s_axil_araddr),
    .full  (addr_full_unused),
    .pop   (addr_pop),
    .dout  (addr_dout),
    .empty (addr_empty)
  );

  axilite_sync_fifo #(.WIDTH(RW), .DEPTH(DEPTH)) u_resp_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (resp_push),
    .din   (resp_din),
    .full  (resp_full),
    .pop   (r_fire),
    .dout  (resp_dout),
    .empty (resp_empty)
  );

  assign s_axil_arready = arready_q;
  assign s_axil_rvalid  = !resp_empty;
  assign s_axil_rdata   = resp_dout[RW-1:2];
  assign s_axil_rresp   = resp_dout[1:0];
  assign reg_rd_en      = busy;
  assign reg_rd_addr    = rd_addr_q;
  assign timeout_errs   = tmo_errs_q;

endmodule

// File: tb/tb_axilite_rd_pipe.sv
// Directed bench for axilite_rd_pipe with TIMEOUT=4, DEPTH=4.
// The register side acks combinationally when enabled; data is fixed or addr^5A5A0000.
module tb_axilite_rd_pipe;

  logic        clk;
  logic        rstn;
  logic [39:0] s_axil_araddr;
  logic [2:0]  s_axil_arprot;
  logic        s_axil_arvalid;
  logic        s_axil_arready;
  logic [31:0] s_axil_rdata;
  logic [1:0]  s_axil_rresp;
  logic        s_axil_rvalid;
  logic        s_axil_rready;
  logic [39:0] reg_rd_addr;
  logic        reg_rd_en;
  logic [31:0] reg_rd_data;
  logic        reg_rd_wait;
  logic        reg_rd_ack;
  logic [15:0] timeout_errs;

  logic        ack_mode;
  logic        use_fixed;
  logic [31:0] fixed_data;

  int errors = 0;
  int checks = 0;

  assign reg_rd_ack  = ack_mode && reg_rd_en;
  assign reg_rd_data = use_fixed ? fixed_data : (reg_rd_addr[31:0] ^ 32'h5A5A_0000);

  axilite_rd_pipe #(.DATA_WIDTH(32), .ADDR_WIDTH(40), .DEPTH(4), .TIMEOUT(4)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .s_axil_araddr  (s_axil_araddr),
    .s_axil_arprot  (s_axil_arprot),
    .s_axil_arvalid (s_axil_arvalid),
    .s_axil_arready (s_axil_arready),
    .s_axil_rdata   (s_axil_rdata),
    .s_axil_rresp   (s_axil_rresp),
    .s_axil_rvalid  (s_axil_rvalid),
    .s_axil_rready  (s_axil_rready),
    .reg_rd_addr    (reg_rd_addr),
    .reg_rd_en      (reg_rd_en),
    .reg_rd_data    (reg_rd_data),
    .reg_rd_wait    (reg_rd_wait),
    .reg_rd_ack     (reg_rd_ack),
    .timeout_errs   (timeout_errs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // caller sits at a negedge; returns at the negedge after the AR handshake
  task automatic ar_send(input logic [39:0] a);
    int n;
    n = 0;
    s_axil_araddr  = a;
    s_axil_arvalid = 1'b1;
    while (!s_axil_arready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ar_ready_wait", {63'd0, s_axil_arready}, 64'd1);
    @(negedge clk);
    s_axil_arvalid = 1'b0;
  endtask

  initial begin
    int en_cycles;
    int accepted;
    int nresp;
    int idx;
    logic [31:0] got [8];

    rstn = 1'b0;
    s_axil_araddr = '0;
    s_axil_arprot = 3'b010;
    s_axil_arvalid = 1'b0;
    s_axil_rready = 1'b1;
    reg_rd_wait = 1'b0;
    ack_mode = 1'b0;
    use_fixed = 1'b0;
    fixed_data = 32'h0;

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_arready", {63'd0, s_axil_arready}, 64'd0);
    chk("rst_rvalid", {63'd0, s_axil_rvalid}, 64'd0);
    chk("rst_rdata", {32'd0, s_axil_rdata}, 64'd0);
    chk("rst_rresp", {62'd0, s_axil_rresp}, 64'd0);
    chk("rst_reg_rd_en", {63'd0, reg_rd_en}, 64'd0);
    chk("rst_tmo_errs", {48'd0, timeout_errs}, 64'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("arready_after_rst", {63'd0, s_axil_arready}, 64'd1);

    // single read, ack in the first enable cycle
    ack_mode = 1'b1;
    use_fixed = 1'b1;
    fixed_data = 32'hDEADBEEF;
    ar_send(40'h10);
    chk("t1_reg_rd_en", {63'd0, reg_rd_en}, 64'd1);
    chk("t1_reg_rd_addr", {24'd0, reg_rd_addr}, 64'h10);
    chk("t1_rvalid_early", {63'd0, s_axil_rvalid}, 64'd0);
    @(negedge clk);
    chk("t1_rvalid", {63'd0, s_axil_rvalid}, 64'd1);
    chk("t1_rdata", {32'd0, s_axil_rdata}, 64'hDEADBEEF);
    chk("t1_rresp", {62'd0, s_axil_rresp}, 64'd0);
    chk("t1_reg_rd_en_off", {63'd0, reg_rd_en}, 64'd0);
    @(negedge clk);
    chk("t1_rvalid_popped", {63'd0, s_axil_rvalid}, 64'd0);
    use_fixed = 1'b0;

    // timeout: no ack, no wait
    ack_mode = 1'b0;
    ar_send(40'h20);
    en_cycles = 0;
    for (int i = 0; i < 20 && reg_rd_en; i++) begin
      en_cycles++;
      @(negedge clk);
    end
    chk("t2_en_cycles", 64'(en_cycles), 64'd4);
    chk("t2_rvalid", {63'd0, s_axil_rvalid}, 64'd1);
    chk("t2_rresp", {62'd0, s_axil_rresp}, 64'd2);
    chk("t2_rdata", {32'd0, s_axil_rdata}, 64'd0);
    chk("t2_tmo_errs", {48'd0, timeout_errs}, 64'd1);
    @(negedge clk);

    // wait freezes the timeout, then ack
    reg_rd_wait = 1'b1;
    ar_send(40'h30);
    repeat (10) @(negedge clk);
    chk("t3_still_en", {63'd0, reg_rd_en}, 64'd1);
    chk("t3_no_resp", {63'd0, s_axil_rvalid}, 64'd0);
    reg_rd_wait = 1'b0;
    ack_mode = 1'b1;
    @(negedge clk);
    chk("t3_rvalid", {63'd0, s_axil_rvalid}, 64'd1);
    chk("t3_rresp", {62'd0, s_axil_rresp}, 64'd0);
    chk("t3_rdata", {32'd0, s_axil_rdata}, 64'h5A5A0030);
    chk("t3_tmo_errs", {48'd0, timeout_errs}, 64'd1);
    @(negedge clk);

    // backpressure: six ARs against DEPTH=4 with rready low
    s_axil_rready = 1'b0;
    accepted = 0;
    idx = 0;
    for (int c = 0; c < 20; c++) begin
      s_axil_arvalid = (idx < 6);
      s_axil_araddr  = 40'h100 + 40'(idx);
      if (s_axil_arvalid && s_axil_arready) begin
        accepted++;
        idx++;
      end
      @(negedge clk);
    end
    chk("t4_accepted", 64'(accepted), 64'd4);
    chk("t4_arready_low", {63'd0, s_axil_arready}, 64'd0);
    chk("t4_rvalid", {63'd0, s_axil_rvalid}, 64'd1);
    chk("t4_head", {32'd0, s_axil_rdata}, 64'h5A5A0100);
    s_axil_rready = 1'b1;
    nresp = 0;
    for (int c = 0; c < 60 && nresp < 6; c++) begin
      s_axil_arvalid = (idx < 6);
      s_axil_araddr  = 40'h100 + 40'(idx);
      if (s_axil_arvalid && s_axil_arready) begin
        accepted++;
        idx++;
      end
      if (s_axil_rvalid) begin
        got[nresp] = s_axil_rdata;
        nresp++;
      end
      @(negedge clk);
    end
    s_axil_arvalid = 1'b0;
    chk("t4_accepted_total", 64'(accepted), 64'd6);
    chk("t4_resp_count", 64'(nresp), 64'd6);
    for (int k = 0; k < 6; k++)
      chk($sformatf("t4_order_%0d", k), {32'd0, got[k]}, 64'h5A5A0100 + 64'(k));

    // reset while a read is in flight
    ack_mode = 1'b0;
    ar_send(40'h200);
    chk("t5_en_before", {63'd0, reg_rd_en}, 64'd1);
    rstn = 1'b0;
    @(negedge clk);
    chk("t5_en_after_rst", {63'd0, reg_rd_en}, 64'd0);
    chk("t5_rvalid_after_rst", {63'd0, s_axil_rvalid}, 64'd0);
    chk("t5_arready_in_rst", {63'd0, s_axil_arready}, 64'd0);
    rstn = 1'b1;
    ack_mode = 1'b1;
    @(negedge clk);
    ar_send(40'h210);
    @(negedge clk);
    chk("t5_rvalid_new", {63'd0, s_axil_rvalid}, 64'd1);
    chk("t5_rdata_new", {32'd0, s_axil_rdata}, 64'h5A5A0210);
    chk("t5_rresp_new", {62'd0, s_axil_rresp}, 64'd0);
    @(negedge clk);
    chk("t5_no_stale_resp", {63'd0, s_axil_rvalid}, 64'd0);
    chk("t5_tmo_errs", {48'd0, timeout_errs}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
